// File: rtl/ifetch_pkg.sv
// Shared constants and types for the instruction-fetch response path.
// Covers the MIPS kseg0/kseg1 window, the translation mask, the reset
// vector and the response-buffer entry layout.
package ifetch_pkg;

    localparam logic [31:0] KSEG0_BASE = 32'h8000_0000;
    localparam logic [31:0] KSEG1_LAST = 32'hBFFF_FFFF;
    localparam logic [31:0] SEG_MASK   = 32'h1FFF_FFFF;
    localparam logic [31:0] RESET_VEC  = 32'hBFC0_0000;
    localparam int          BUF_DEPTH  = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adel;
    } buf_entry_t;

    // kseg0/kseg1 fold onto the low 512 MB; everything else is identity-mapped
    function automatic logic [31:0] xlate(input logic [31:0] va);
        if (va >= KSEG0_BASE && va <= KSEG1_LAST)
            return va & SEG_MASK;
        return va;
    endfunction

endpackage

// File: rtl/ifetch_resp_if.sv
// Fetch request / instruction RAM / response bundle.
// slave is the fetch unit side, master is the PC stage + RAM + consumer side.
interface ifetch_resp_if;

    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        flush;
    logic        mem_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_inst;
    logic [31:0] rsp_pc;
    logic        rsp_adel;

    modport slave (
        input  req_valid, req_addr, flush, mem_rdata, rsp_ready,
        output req_ready, mem_en, mem_addr, rsp_valid, rsp_inst, rsp_pc, rsp_adel
    );

    modport master (
        output req_valid, req_addr, flush, mem_rdata, rsp_ready,
        input  req_ready, mem_en, mem_addr, rsp_valid, rsp_inst, rsp_pc, rsp_adel
    );

endinterface

// File: rtl/ifetch_resp_fifo.sv
// Two-entry in-order response buffer. Flush wins over push and pop.
// Storage is reset so the head reads as all-zero straight out of reset.
module ifetch_resp_fifo
    import ifetch_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    input  buf_entry_t din,
    output buf_entry_t dout,
    output logic [1:0] count
);

    buf_entry_t mem [BUF_DEPTH];
    logic       wr_ptr;
    logic       rd_ptr;
    logic       do_pop;

    // popping an empty buffer is ignored; push on full is only legal with pop
    assign do_pop = pop && (count != 2'd0);
    assign dout   = mem[rd_ptr];

    // storage, pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/ifetch_resp.sv
// Instruction fetch response unit: issues one synchronous RAM read per
// accepted PC, returns {pc, inst, adel} in order with 2-cycle latency.
// Optional alignment check enabled by defining IFETCH_ADDR_CHECK_EN.
module ifetch_resp
    import ifetch_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    ifetch_resp_if.slave  bus
);

    logic        alive;
    logic        rd_pend;
    logic [31:0] rd_pc;
    logic        rd_adel;
    logic        accept;
    logic        pop;
    logic        push;
    logic        misalign;
    logic [1:0]  count;
    logic [2:0]  outstanding;
    logic [31:0] phys;
    buf_entry_t  wr_entry;
    buf_entry_t  head;

`ifdef IFETCH_ADDR_CHECK_EN
    assign misalign = |bus.req_addr[1:0];
`else
    assign misalign = 1'b0;
`endif

    // outstanding = buffered entries + the read whose data arrives next cycle
    assign outstanding   = {1'b0, count} + {2'b00, rd_pend};
    assign pop           = bus.rsp_valid && bus.rsp_ready;
    assign bus.req_ready = alive && !bus.flush
                         && ((outstanding - {2'b00, pop}) < 3'(BUF_DEPTH));
    assign accept        = bus.req_valid && bus.req_ready;

    // misaligned fetches take a response slot but never touch the RAM
    assign phys         = xlate(bus.req_addr);
    assign bus.mem_en   = accept && !misalign;
    assign bus.mem_addr = {phys[31:2], 2'b00};

    // a read landing in a flush cycle is dropped rather than buffered
    assign push          = rd_pend && !bus.flush;
    assign wr_entry.pc   = rd_pc;
    assign wr_entry.inst = rd_adel ? 32'h0 : bus.mem_rdata;
    assign wr_entry.adel = rd_adel;

    assign bus.rsp_valid = (count != 2'd0);
    assign bus.rsp_inst  = head.inst;
    assign bus.rsp_pc    = head.pc;
    assign bus.rsp_adel  = head.adel;

    // track the read in flight and hold its PC until the data returns
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alive   <= 1'b0;
            rd_pend <= 1'b0;
            rd_pc   <= RESET_VEC;
            rd_adel <= 1'b0;
        end else begin
            alive   <= 1'b1;
            rd_pend <= accept;
            if (accept) begin
                rd_pc   <= bus.req_addr;
                rd_adel <= misalign;
            end
        end
    end

    ifetch_resp_fifo u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (bus.flush),
        .din   (wr_entry),
        .dout  (head),
        .count (count)
    );

endmodule
